mem_scrub_checker: RTL

MEM_SCRUB_CHECKER -- requirements
Module: mem_scrub_checker

---
 rtl/mem_test_pkg.sv | 24 ++
 rtl/mem_scrub_checker.sv | 102 ++++++++++
 2 files changed

// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory scrub/checker: FSM states, address width
// and the alternating expected-pattern helper.
package mem_test_pkg;

    localparam int ADDR_W = 12;
    localparam int PAT_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } scrub_state_e;

    // Expected word for an address: odd addresses hold po, even hold pe.
    function automatic logic [PAT_W-1:0] exp_pat(
        input logic [ADDR_W-1:0] a,
        input logic [PAT_W-1:0]  pe,
        input logic [PAT_W-1:0]  po
    );
        return a[0] ? po : pe;
    endfunction

endpackage

// File: rtl/mem_scrub_checker.sv
// Sweeps a memory comparing every word to an alternating pattern, counting
// mismatches and either writing data back unchanged or rewriting the pattern.
module mem_scrub_checker
    import mem_test_pkg::*;
#(
    parameter int                 WID_MEM   = 18,
    parameter int                 DEPTH_MEM = 4096,
    parameter logic [WID_MEM-1:0] PAT_EVEN  = 18'h2AAAA,
    parameter logic [WID_MEM-1:0] PAT_ODD   = 18'h15555
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               fix_en,
    output logic [ADDR_W-1:0]  raddr,
    output logic [ADDR_W-1:0]  waddr,
    output logic [WID_MEM-1:0] din,
    input  logic [WID_MEM-1:0] dout,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W:0]    err_count,
    output logic               first_err_valid,
    output logic [ADDR_W-1:0]  first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
    localparam logic [ADDR_W:0]   ERR_MAX   = (ADDR_W + 1)'(DEPTH_MEM);

    scrub_state_e       state;
    logic               cmp_vld;
    logic               fix_lat;
    logic [WID_MEM-1:0] exp_w;
    logic               mismatch;

    // The compare stage lines up with waddr: dout for address a arrives while waddr == a.
    always_comb begin
        exp_w    = WID_MEM'(exp_pat(waddr, PAT_W'(PAT_EVEN), PAT_W'(PAT_ODD)));
        mismatch = cmp_vld && (dout != exp_w);
        din      = dout;
        if (cmp_vld && fix_lat)
            din = exp_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            raddr           <= '0;
            waddr           <= '0;
            cmp_vld         <= 1'b0;
            fix_lat         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            waddr   <= raddr;
            cmp_vld <= (state == ST_SWEEP);
            done    <= 1'b0;

            if (mismatch) begin
                if (err_count != ERR_MAX)
                    err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= waddr;
                end
            end

            case (state)
                ST_IDLE: begin
                    raddr <= '0;
                    if (start) begin
                        state           <= ST_SWEEP;
                        busy            <= 1'b1;
                        fix_lat         <= fix_en;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_addr  <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (raddr == LAST_ADDR) begin
                        state <= ST_DRAIN;
                        raddr <= '0;
                    end else begin
                        raddr <= raddr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
